// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: serial scanner that shifts W-bit words MSB-first through an
// overlapping Mealy detector for the bit patterns 101 and 110, and counts
// each pattern in a saturating counter.
//
// Ports:
//   i_clk      - clock; all state updates on the rising edge
//   i_reset    - synchronous active-high reset, overrides everything
//   i_data     - word to scan, MSB first
//   i_valid    - i_data is valid; captured when o_ready is high
//   o_ready    - block is idle and not being cleared this cycle
//   i_clear    - in IDLE: zero the counters and the detector state
//   o_hit      - registered per-bit code: 2'b10 = 101, 2'b11 = 110, 2'b00 = none
//   o_cnt101   - saturating count of 101 detections
//   o_cnt110   - saturating count of 110 detections
//   o_busy     - high while shifting or in the DONE cycle
//   o_done     - one-cycle pulse once a word has been fully scanned
module seq_scan_ctrl #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [W-1:0]     i_data,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_clear,
    output logic [1:0]       o_hit,
    output logic [CNT_W-1:0] o_cnt101,
    output logic [CNT_W-1:0] o_cnt110,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned BitCntW = $clog2(W + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    // DetD1: last bit 1 (no pending pattern prefix of 11/10)
    // DetD2: last two bits 11
    // DetD3: last two bits 10
    typedef enum logic [1:0] {
        DetD0,
        DetD1,
        DetD2,
        DetD3
    } det_e;

    state_e             state_q;
    det_e               det_q;
    det_e               det_d;
    logic [1:0]         code_d;
    logic [W-1:0]       shreg_q;
    logic [BitCntW-1:0] bitcnt_q;
    logic [1:0]         hit_q;
    logic [CNT_W-1:0]   cnt101_q;
    logic [CNT_W-1:0]   cnt110_q;
    logic               busy_q;
    logic               done_q;
    logic               scan_bit;

    assign scan_bit = shreg_q[W-1];

    // Detector next state and Mealy output for the bit currently at the MSB.
    always_comb begin
        det_d  = DetD0;
        code_d = 2'b00;
        unique case (det_q)
            DetD0: det_d = scan_bit ? DetD1 : DetD0;
            DetD1: det_d = scan_bit ? DetD2 : DetD3;
            DetD2: begin
                det_d  = scan_bit ? DetD2 : DetD3;
                code_d = scan_bit ? 2'b00 : 2'b11;
            end
            DetD3: begin
                det_d  = scan_bit ? DetD1 : DetD0;
                code_d = scan_bit ? 2'b10 : 2'b00;
            end
            default: begin
                det_d  = DetD0;
                code_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= StIdle;
            det_q    <= DetD0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            hit_q    <= 2'b00;
            cnt101_q <= '0;
            cnt110_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // o_hit and o_done are single-cycle unless re-asserted below.
            hit_q  <= 2'b00;
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_clear) begin
                        cnt101_q <= '0;
                        cnt110_q <= '0;
                        det_q    <= DetD0;
                    end else if (i_valid) begin
                        shreg_q  <= i_data;
                        bitcnt_q <= BitCntW'(W);
                        state_q  <= StShift;
                        busy_q   <= 1'b1;
                    end
                end
                StShift: begin
                    det_q    <= det_d;
                    hit_q    <= code_d;
                    shreg_q  <= {shreg_q[W-2:0], 1'b0};
                    bitcnt_q <= bitcnt_q - BitCntW'(1);
                    // Counters move on the same edge as o_hit so they are
                    // final by the time o_done is seen.
                    if (code_d == 2'b10 && cnt101_q != '1) begin
                        cnt101_q <= cnt101_q + CNT_W'(1);
                    end
                    if (code_d == 2'b11 && cnt110_q != '1) begin
                        cnt110_q <= cnt110_q + CNT_W'(1);
                    end
                    if (bitcnt_q == BitCntW'(1)) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready  = (state_q == StIdle) && !i_clear;
    assign o_hit    = hit_q;
    assign o_cnt101 = cnt101_q;
    assign o_cnt110 = cnt110_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;

endmodule
